// File: rtl/player_pkg.sv
// Shared types and constants for the player sprite animation sequencer.
// Frame map, state/status encodings and default per-step hold lengths.
package player_pkg;

    localparam int STEP_W = 3;
    localparam int HOLD_W = 4;
    localparam int SEL_W  = 5;

    typedef enum logic [3:0] {
        STAT_IDLE = 4'd0,
        STAT_WALK = 4'd1,
        STAT_AIR  = 4'd2
    } status_t;

    typedef enum logic [1:0] {
        A_IDLE = 2'd0,
        A_WALK = 2'd1,
        A_AIR  = 2'd2,
        A_LAND = 2'd3
    } anim_state_t;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } step_mode_t;

    localparam logic [SEL_W-1:0]  IDLE_BASE  = 5'd0;
    localparam logic [SEL_W-1:0]  WALK_BASE  = 5'd4;
    localparam logic [SEL_W-1:0]  AIR_BASE   = 5'd10;
    localparam logic [SEL_W-1:0]  LAND_BASE  = 5'd13;
    localparam logic [STEP_W-1:0] IDLE_COUNT = 3'd4;
    localparam logic [STEP_W-1:0] WALK_COUNT = 3'd6;
    localparam logic [STEP_W-1:0] AIR_COUNT  = 3'd3;
    localparam logic [STEP_W-1:0] LAND_COUNT = 3'd2;

    localparam int IDLE_HOLD_DEF = 8;
    localparam int WALK_HOLD_DEF = 4;
    localparam int AIR_HOLD_DEF  = 6;
    localparam int LAND_HOLD_DEF = 3;

    function automatic logic [SEL_W-1:0] anim_base(input anim_state_t s);
        case (s)
            A_WALK:  return WALK_BASE;
            A_AIR:   return AIR_BASE;
            A_LAND:  return LAND_BASE;
            default: return IDLE_BASE;
        endcase
    endfunction

endpackage

// File: rtl/anim_step_counter.sv
// Step/hold counter for one animation: advances step every hold_len ticks, wraps or saturates.
// Latency: step_nxt is the value loaded at the coming edge; no backpressure, one update per tick.
module anim_step_counter
    import player_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic [STEP_W-1:0] count,
    input  logic [HOLD_W-1:0] hold_len,
    input  step_mode_t        mode,
    output logic [STEP_W-1:0] step_nxt,
    output logic              last_done
);

    logic [STEP_W-1:0] step_q, step_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              hold_end;
    logic              step_end;

    assign hold_end = (hold_q >= hold_len - 4'd1);
    assign step_end = (step_q >= count - 3'd1);

    always_comb begin
        step_d = step_q;
        hold_d = hold_q + 4'd1;
        if (clear) begin
            step_d = '0;
            hold_d = '0;
        end else if (hold_end) begin
            hold_d = '0;
            // Saturating mode parks on the last step while hold keeps cycling.
            if (!step_end) begin
                step_d = step_q + 3'd1;
            end else if (mode == MODE_WRAP) begin
                step_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q <= '0;
            hold_q <= '0;
        end else begin
            step_q <= step_d;
            hold_q <= hold_d;
        end
    end

    assign step_nxt  = step_d;
    assign last_done = hold_end && step_end;

endmodule

// File: rtl/player_anim.sv
// Player sprite animation sequencer: status/X per frame -> registered sprite index and facing.
// Latency: all outputs one frame_clk edge after inputs; no backpressure, consumes every tick.
module player_anim
    import player_pkg::*;
#(
    parameter int IDLE_HOLD = IDLE_HOLD_DEF,
    parameter int WALK_HOLD = WALK_HOLD_DEF,
    parameter int AIR_HOLD  = AIR_HOLD_DEF,
    parameter int LAND_HOLD = LAND_HOLD_DEF,
    parameter int X_RESET   = 320
) (
    input  logic             frame_clk,
    input  logic             Reset,
    input  logic [9:0]       BallX,
    input  logic [3:0]       BallStatus,
    output logic [SEL_W-1:0] SpriteSel,
    output logic             Facing,
    output logic [1:0]       AnimState
);

    anim_state_t       state_q, state_d;
    status_t           status;
    logic [SEL_W-1:0]  sprite_sel_q, sprite_sel_d;
    logic              facing_q, facing_d;
    logic [9:0]        prev_x_q;
    logic              clear;
    logic [STEP_W-1:0] cnt_len;
    logic [HOLD_W-1:0] hold_len;
    step_mode_t        mode;
    logic [STEP_W-1:0] step_nxt;
    logic              last_done;

    always_comb begin
        case (BallStatus)
            STAT_WALK: status = STAT_WALK;
            STAT_AIR:  status = STAT_AIR;
            default:   status = STAT_IDLE;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_len  = IDLE_COUNT;
        hold_len = 4'(IDLE_HOLD);
        mode     = MODE_WRAP;
        case (state_q)
            A_IDLE: begin
                if (status == STAT_WALK)     state_d = A_WALK;
                else if (status == STAT_AIR) state_d = A_AIR;
            end
            A_WALK: begin
                cnt_len  = WALK_COUNT;
                hold_len = 4'(WALK_HOLD);
                if (status == STAT_IDLE)     state_d = A_IDLE;
                else if (status == STAT_AIR) state_d = A_AIR;
            end
            A_AIR: begin
                cnt_len  = AIR_COUNT;
                hold_len = 4'(AIR_HOLD);
                mode     = MODE_SAT;
                if (status == STAT_IDLE)      state_d = A_LAND;
                else if (status == STAT_WALK) state_d = A_WALK;
            end
            default: begin
                cnt_len  = LAND_COUNT;
                hold_len = 4'(LAND_HOLD);
                if (status == STAT_AIR)       state_d = A_AIR;
                else if (status == STAT_WALK) state_d = A_WALK;
                else if (last_done)           state_d = A_IDLE;
            end
        endcase
    end

    // Any state change, including the landing exit, restarts the counter.
    assign clear        = (state_d != state_q);
    assign sprite_sel_d = anim_base(state_d) + SEL_W'(step_nxt);

    always_comb begin
        facing_d = facing_q;
        if (BallX < prev_x_q)      facing_d = 1'b1;
        else if (BallX > prev_x_q) facing_d = 1'b0;
    end

    anim_step_counter u_step (
        .clk       (frame_clk),
        .rst_n     (Reset),
        .clear     (clear),
        .count     (cnt_len),
        .hold_len  (hold_len),
        .mode      (mode),
        .step_nxt  (step_nxt),
        .last_done (last_done)
    );

    always_ff @(posedge frame_clk or negedge Reset) begin
        if (!Reset) begin
            state_q      <= A_IDLE;
            sprite_sel_q <= '0;
            facing_q     <= 1'b0;
            prev_x_q     <= 10'(X_RESET);
        end else begin
            state_q      <= state_d;
            sprite_sel_q <= sprite_sel_d;
            facing_q     <= facing_d;
            prev_x_q     <= BallX;
        end
    end

    assign SpriteSel = sprite_sel_q;
    assign Facing    = facing_q;
    assign AnimState = state_q;

endmodule

// File: tb/tb_player_anim.sv
// Self-checking bench for player_anim: directed scenarios plus randomized status/X traffic.
module tb_player_anim;

    localparam int IH = 8, WH = 4, AH = 6, LH = 3, XR = 320;

    logic       frame_clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] ball_x = 10'd320;
    logic [3:0] ball_status = 4'd0;
    logic [4:0] sprite_sel;
    logic       facing;
    logic [1:0] anim_state;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: state, ticks since entering it, facing and last X.
    int         m_state;
    int         m_t;
    logic [9:0] m_prevx;
    logic       m_face;

    player_anim #(
        .IDLE_HOLD(IH), .WALK_HOLD(WH), .AIR_HOLD(AH), .LAND_HOLD(LH), .X_RESET(XR)
    ) dut (
        .frame_clk  (frame_clk),
        .Reset      (rst_n),
        .BallX      (ball_x),
        .BallStatus (ball_status),
        .SpriteSel  (sprite_sel),
        .Facing     (facing),
        .AnimState  (anim_state)
    );

    always #5 frame_clk = ~frame_clk;

    function automatic void model_reset();
        m_state = 0;
        m_t     = 0;
        m_prevx = 10'(XR);
        m_face  = 1'b0;
    endfunction

    function automatic int exp_sprite();
        int s;
        case (m_state)
            0: return (m_t / IH) % 4;
            1: return 4 + (m_t / WH) % 6;
            2: begin
                s = m_t / AH;
                return 10 + ((s > 2) ? 2 : s);
            end
            default: return 13 + m_t / LH;
        endcase
    endfunction

    function automatic logic [7:0] exp_vec();
        return {5'(exp_sprite()), 2'(m_state), m_face};
    endfunction

    function automatic void model_step(input logic [3:0] st, input logic [9:0] x);
        int s, nxt;
        s   = (st == 4'd1) ? 1 : (st == 4'd2) ? 2 : 0;
        nxt = m_state;
        case (m_state)
            0: if (s != 0) nxt = s;
            1: if (s != 1) nxt = s;
            2: if (s == 0) nxt = 3; else if (s == 1) nxt = 1;
            default: begin
                if (s != 0) nxt = s;
                else if (m_t + 1 == 2 * LH) nxt = 0;
            end
        endcase
        if (nxt != m_state) begin
            m_state = nxt;
            m_t     = 0;
        end else begin
            m_t = m_t + 1;
        end
        if (x < m_prevx)      m_face = 1'b1;
        else if (x > m_prevx) m_face = 1'b0;
        m_prevx = x;
    endfunction

    task automatic tick(input logic [3:0] st, input logic [9:0] x);
        ball_status = st;
        ball_x      = x;
        @(posedge frame_clk);
        model_step(st, x);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ball_status = 4'd0;
        ball_x = 10'd320;
        repeat (3) @(posedge frame_clk);
        #1;
        n_cmp++;
        if ({sprite_sel, anim_state, facing} !== 8'd0) begin
            n_err++;
            $display("FAIL reset_hold: got sel=%0d st=%0d face=%0d, want 0/0/0", sprite_sel, anim_state, facing);
        end
        @(negedge frame_clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_idle_cycle();
        for (int i = 1; i <= 32; i++) begin
            tick(4'd0, 10'd320);
            n_cmp++;
            if ({sprite_sel, anim_state, facing} !== exp_vec()) begin
                n_err++;
                $display("FAIL idle_model t=%0d: got %h want %h", i, {sprite_sel, anim_state, facing}, exp_vec());
            end
            if (i == 8 || i == 24 || i == 32) begin
                n_cmp++;
                if (sprite_sel !== ((i == 8) ? 5'd1 : (i == 24) ? 5'd3 : 5'd0)) begin
                    n_err++;
                    $display("FAIL idle_step t=%0d: got sel=%0d", i, sprite_sel);
                end
            end
        end
    endtask

    task automatic test_walk();
        for (int k = 0; k <= 24; k++) begin
            tick(4'd1, 10'd320);
            n_cmp++;
            if ({sprite_sel, anim_state, facing} !== exp_vec()) begin
                n_err++;
                $display("FAIL walk_model k=%0d: got %h want %h", k, {sprite_sel, anim_state, facing}, exp_vec());
            end
            if (k == 0 || k == 20 || k == 24) begin
                n_cmp++;
                if ({sprite_sel, anim_state} !== {((k == 20) ? 5'd9 : 5'd4), 2'd1}) begin
                    n_err++;
                    $display("FAIL walk_step k=%0d: got sel=%0d st=%0d", k, sprite_sel, anim_state);
                end
            end
        end
    endtask

    task automatic test_air_hold();
        logic [4:0] want;
        for (int k = 0; k <= 40; k++) begin
            tick(4'd2, 10'd320);
            want = (k < 6) ? 5'd10 : (k < 12) ? 5'd11 : 5'd12;
            n_cmp++;
            if ({sprite_sel, anim_state, facing} !== {want, 2'd2, m_face}) begin
                n_err++;
                $display("FAIL air_hold k=%0d: got sel=%0d st=%0d want sel=%0d st=2", k, sprite_sel, anim_state, want);
            end
        end
    endtask

    task automatic test_land();
        logic [4:0] want;
        for (int k = 0; k <= 6; k++) begin
            tick(4'd0, 10'd320);
            want = (k < 3) ? 5'd13 : (k < 6) ? 5'd14 : 5'd0;
            n_cmp++;
            if ({sprite_sel, anim_state} !== {want, (k < 6) ? 2'd3 : 2'd0}) begin
                n_err++;
                $display("FAIL land_seq k=%0d: got sel=%0d st=%0d want sel=%0d", k, sprite_sel, anim_state, want);
            end
        end
    endtask

    task automatic test_land_interrupt();
        tick(4'd2, 10'd320);
        tick(4'd0, 10'd320);
        tick(4'd0, 10'd320);
        tick(4'd1, 10'd320);
        n_cmp++;
        if ({sprite_sel, anim_state} !== {5'd4, 2'd1} || exp_vec() !== {sprite_sel, anim_state, facing}) begin
            n_err++;
            $display("FAIL land_interrupt: got sel=%0d st=%0d want sel=4 st=1", sprite_sel, anim_state);
        end
    endtask

    task automatic test_facing();
        logic [9:0] xs [4];
        logic       wf [4];
        xs = '{10'd320, 10'd318, 10'd318, 10'd322};
        wf = '{1'b0, 1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 4; k++) begin
            tick(4'd0, xs[k]);
            if (k > 0) begin
                n_cmp++;
                if (facing !== wf[k] || facing !== m_face) begin
                    n_err++;
                    $display("FAIL facing k=%0d: got %0d want %0d", k, facing, wf[k]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 8; k++) begin
            tick((k % 2 == 0) ? 4'd1 : 4'd2, 10'd320);
            n_cmp++;
            if ({sprite_sel, anim_state} !== ((k % 2 == 0) ? {5'd4, 2'd1} : {5'd10, 2'd2})) begin
                n_err++;
                $display("FAIL back_to_back k=%0d: got sel=%0d st=%0d", k, sprite_sel, anim_state);
            end
        end
    endtask

    task automatic test_reset_mid_walk();
        tick(4'd0, 10'd320);
        for (int k = 0; k <= 20; k++) tick(4'd1, 10'(300 - k));
        n_cmp++;
        if ({sprite_sel, facing} !== {5'd9, 1'b1}) begin
            n_err++;
            $display("FAIL pre_reset_walk: got sel=%0d face=%0d want 9/1", sprite_sel, facing);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({sprite_sel, anim_state, facing} !== 8'd0) begin
            n_err++;
            $display("FAIL reset_async: got sel=%0d st=%0d face=%0d want 0/0/0", sprite_sel, anim_state, facing);
        end
        @(negedge frame_clk);
        rst_n = 1'b1;
        model_reset();
        tick(4'd0, 10'd320);
        tick(4'd0, 10'd319);
        n_cmp++;
        if ({sprite_sel, anim_state, facing} !== exp_vec() || facing !== 1'b1) begin
            n_err++;
            $display("FAIL reset_prevx: got %h want %h", {sprite_sel, anim_state, facing}, exp_vec());
        end
    endtask

    task automatic test_random();
        logic [3:0] st;
        logic [9:0] x;
        st = 4'd0;
        x  = ball_x;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 9) == 0) st = 4'($urandom_range(0, 3));
            if ($urandom_range(0, 30) == 0) st = 4'($urandom_range(0, 15));
            x = x + 10'($urandom_range(0, 4)) - 10'd2;
            tick(st, x);
            n_cmp++;
            if ({sprite_sel, anim_state, facing} !== exp_vec()) begin
                n_err++;
                $display("FAIL random i=%0d st=%0d x=%0d: got %h want %h", i, st, x,
                         {sprite_sel, anim_state, facing}, exp_vec());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_idle_cycle();
        test_walk();
        test_air_hold();
        test_land();
        test_land_interrupt();
        test_facing();
        test_back_to_back();
        test_reset_mid_walk();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
